// File: rtl/reg_file_fwd_pkg.sv
// reg_file_fwd_pkg
//   Shared definitions for the ID-stage register file with forwarding.
//   - REG_ADDR_W / DATA_W : default GPR index and data widths
//   - REG_COUNT           : number of GPRs at the default index width
//   - ZERO_REG            : hard-wired zero register index
//   - fwd_src_e           : which source drives a read port
//   - pick_src            : priority selection EX > MEM > WB > array
package reg_file_fwd_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_COUNT  = 2 ** REG_ADDR_W;
   localparam int unsigned ZERO_REG   = 0;

   typedef enum logic [2:0] {
      SrcZero,
      SrcEx,
      SrcMem,
      SrcWb,
      SrcArray
   } fwd_src_e;

   // First match wins. An inactive port (disabled or reading r0) always
   // resolves to zero so it can neither forward nor stall.
   function automatic fwd_src_e pick_src(input logic active,
                                         input logic ex_hit,
                                         input logic mem_hit,
                                         input logic wb_hit);
      fwd_src_e src;
      if (!active) begin
         src = SrcZero;
      end else if (ex_hit) begin
         src = SrcEx;
      end else if (mem_hit) begin
         src = SrcMem;
      end else if (wb_hit) begin
         src = SrcWb;
      end else begin
         src = SrcArray;
      end
      return src;
   endfunction

endpackage

// File: rtl/reg_file_fwd_reg_array.sv
// reg_file_fwd_reg_array
//   GPR storage for reg_file_fwd: 2**ADDR_WIDTH x DATA_WIDTH entries,
//   synchronous clear on reset, one write port (WB), two async read ports.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset, clears every entry
//     write_en     WB write enable
//     write_addr   WB destination (writes to register 0 are dropped)
//     write_data   WB data
//     read_addr_1  read port 1 index
//     read_data_1  read port 1 data (raw array contents, read-before-write)
//     read_addr_2  read port 2 index
//     read_data_2  read port 2 data (raw array contents, read-before-write)
module reg_file_fwd_reg_array
   import reg_file_fwd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
   parameter int unsigned DATA_WIDTH = DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   output logic [DATA_WIDTH-1:0] read_data_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   output logic [DATA_WIDTH-1:0] read_data_2
);

   localparam int unsigned Count = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [Count];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Count; i++) begin
            regs_q[i] <= '0;
         end
      end else if (write_en && (write_addr != ADDR_WIDTH'(ZERO_REG))) begin
         regs_q[write_addr] <= write_data;
      end
   end

   assign read_data_1 = regs_q[read_addr_1];
   assign read_data_2 = regs_q[read_addr_2];

endmodule

// File: rtl/reg_file_fwd.sv
// reg_file_fwd
//   ID-stage operand source: GPR array plus EX/MEM/WB forwarding on both
//   read ports, and a load-use stall request when an operand depends on a
//   load still in EX. Holds no state other than the register array.
//   Optional feature: define REG_BYPASS_WB_EN to forward the WB write to a
//   same-cycle read (write-through); otherwise the array is read before write.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     read_en_1/2, read_addr_1/2     operand read enables and indices
//     ex_write_en/addr/data          EX-stage destination (data invalid for loads)
//     ex_load_flag                   EX instruction is a load
//     mem_write_en/addr/data         MEM-stage destination, load data valid
//     wb_write_en/addr/data          WB commit port into the array
//     read_data_1/2                  forwarded operands (0 when disabled/r0/reset)
//     load_related                   load-use stall request
module reg_file_fwd
   import reg_file_fwd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
   parameter int unsigned DATA_WIDTH = DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   input  logic                  read_en_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   input  logic                  ex_write_en,
   input  logic [ADDR_WIDTH-1:0] ex_write_addr,
   input  logic [DATA_WIDTH-1:0] ex_write_data,
   input  logic                  ex_load_flag,
   input  logic                  mem_write_en,
   input  logic [ADDR_WIDTH-1:0] mem_write_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic                  wb_write_en,
   input  logic [ADDR_WIDTH-1:0] wb_write_addr,
   input  logic [DATA_WIDTH-1:0] wb_write_data,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic                  load_related
);

   logic [DATA_WIDTH-1:0] arr_data_1;
   logic [DATA_WIDTH-1:0] arr_data_2;

   reg_file_fwd_reg_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_reg_array (
      .clk         (clk),
      .rst         (rst),
      .write_en    (wb_write_en),
      .write_addr  (wb_write_addr),
      .write_data  (wb_write_data),
      .read_addr_1 (read_addr_1),
      .read_data_1 (arr_data_1),
      .read_addr_2 (read_addr_2),
      .read_data_2 (arr_data_2)
   );

   // A port is active only when enabled and not reading r0; every hit below
   // is qualified by it, so r0 is never forwarded and never stalls.
   logic active_1;
   logic active_2;
   assign active_1 = read_en_1 && (read_addr_1 != ADDR_WIDTH'(ZERO_REG));
   assign active_2 = read_en_2 && (read_addr_2 != ADDR_WIDTH'(ZERO_REG));

   logic ex_hit_1;
   logic ex_hit_2;
   logic mem_hit_1;
   logic mem_hit_2;
   logic wb_hit_1;
   logic wb_hit_2;

   assign ex_hit_1  = active_1 && ex_write_en  && (read_addr_1 == ex_write_addr);
   assign ex_hit_2  = active_2 && ex_write_en  && (read_addr_2 == ex_write_addr);
   assign mem_hit_1 = active_1 && mem_write_en && (read_addr_1 == mem_write_addr);
   assign mem_hit_2 = active_2 && mem_write_en && (read_addr_2 == mem_write_addr);

`ifdef REG_BYPASS_WB_EN
   assign wb_hit_1  = active_1 && wb_write_en  && (read_addr_1 == wb_write_addr);
   assign wb_hit_2  = active_2 && wb_write_en  && (read_addr_2 == wb_write_addr);
`else
   // No write-through: a same-cycle read sees the old array value.
   assign wb_hit_1  = 1'b0;
   assign wb_hit_2  = 1'b0;
`endif

   fwd_src_e src_1;
   fwd_src_e src_2;
   assign src_1 = pick_src(active_1, ex_hit_1, mem_hit_1, wb_hit_1);
   assign src_2 = pick_src(active_2, ex_hit_2, mem_hit_2, wb_hit_2);

   // An EX hit on a load still selects EX: the value is don't-care because
   // the stall holds the instruction, and lower stages must not leak through.
   always_comb begin
      read_data_1 = '0;
      if (!rst) begin
         unique case (src_1)
            SrcEx:    read_data_1 = ex_write_data;
            SrcMem:   read_data_1 = mem_write_data;
            SrcWb:    read_data_1 = wb_write_data;
            SrcArray: read_data_1 = arr_data_1;
            default:  read_data_1 = '0;
         endcase
      end
   end

   always_comb begin
      read_data_2 = '0;
      if (!rst) begin
         unique case (src_2)
            SrcEx:    read_data_2 = ex_write_data;
            SrcMem:   read_data_2 = mem_write_data;
            SrcWb:    read_data_2 = wb_write_data;
            SrcArray: read_data_2 = arr_data_2;
            default:  read_data_2 = '0;
         endcase
      end
   end

   always_comb begin
      load_related = 1'b0;
      if (!rst) begin
         load_related = ex_load_flag && (ex_hit_1 || ex_hit_2);
      end
   end

endmodule

// File: tb/tb_reg_file_fwd.sv
// tb_reg_file_fwd
//   Table of directed vectors for the listed corner cases, then randomized
//   traffic checked against a simple array-plus-priority reference model.
module tb_reg_file_fwd;

`ifdef REG_BYPASS_WB_EN
   localparam logic Byp = 1'b1;
`else
   localparam logic Byp = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        read_en_1, read_en_2;
   logic [4:0]  read_addr_1, read_addr_2;
   logic        ex_write_en, ex_load_flag;
   logic [4:0]  ex_write_addr;
   logic [31:0] ex_write_data;
   logic        mem_write_en;
   logic [4:0]  mem_write_addr;
   logic [31:0] mem_write_data;
   logic        wb_write_en;
   logic [4:0]  wb_write_addr;
   logic [31:0] wb_write_data;
   logic [31:0] read_data_1, read_data_2;
   logic        load_related;

   always #5 clk = ~clk;

   reg_file_fwd dut (
      .clk            (clk),
      .rst            (rst),
      .read_en_1      (read_en_1),
      .read_addr_1    (read_addr_1),
      .read_en_2      (read_en_2),
      .read_addr_2    (read_addr_2),
      .ex_write_en    (ex_write_en),
      .ex_write_addr  (ex_write_addr),
      .ex_write_data  (ex_write_data),
      .ex_load_flag   (ex_load_flag),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .wb_write_en    (wb_write_en),
      .wb_write_addr  (wb_write_addr),
      .wb_write_data  (wb_write_data),
      .read_data_1    (read_data_1),
      .read_data_2    (read_data_2),
      .load_related   (load_related)
   );

   typedef struct {
      logic        rst;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic        exen;
      logic [4:0]  exa;
      logic [31:0] exd;
      logic        exl;
      logic        memen;
      logic [4:0]  mema;
      logic [31:0] memd;
      logic        wben;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic [31:0] e1;
      logic        c1;
      logic [31:0] e2;
      logic        c2;
      logic        el;
   } vec_t;

   localparam int NumVec = 17;
   vec_t vecs [NumVec];

   int passed = 0;
   int total  = 0;

   logic [31:0] model [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      rst            = v.rst;
      read_en_1      = v.re1;
      read_addr_1    = v.ra1;
      read_en_2      = v.re2;
      read_addr_2    = v.ra2;
      ex_write_en    = v.exen;
      ex_write_addr  = v.exa;
      ex_write_data  = v.exd;
      ex_load_flag   = v.exl;
      mem_write_en   = v.memen;
      mem_write_addr = v.mema;
      mem_write_data = v.memd;
      wb_write_en    = v.wben;
      wb_write_addr  = v.wba;
      wb_write_data  = v.wbd;
   endtask

   // Advance one clock and apply the architectural effect of this cycle.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (wb_write_en && wb_write_addr != 5'd0) begin
         model[wb_write_addr] = wb_write_data;
      end
      #1;
   endtask

   function automatic logic ref_stall(input logic en, input logic [4:0] a);
      return !rst && en && a != 5'd0 && ex_write_en && ex_load_flag && a == ex_write_addr;
   endfunction

   function automatic logic [31:0] ref_read(input logic en, input logic [4:0] a);
      if (rst || !en || a == 5'd0) return 32'h0;
      if (ex_write_en && ex_write_addr == a) return ex_write_data;
      if (mem_write_en && mem_write_addr == a) return mem_write_data;
      if (Byp && wb_write_en && wb_write_addr == a) return wb_write_data;
      return model[a];
   endfunction

   initial begin
      logic s1, s2;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // rst re1 ra1 re2 ra2 | ex en/addr/data/load | mem en/addr/data | wb en/addr/data
      // | exp1 chk1 exp2 chk2 exp_load
      vecs[0]  = '{1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 32'hAAAA, 1'b1,
                   1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd5, 32'h1234,
                   32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234,
                   Byp ? 32'h1234 : 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 32'h7777, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555,
                   32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF,
                   Byp ? 32'hDEADBEEF : 32'h0, 1'b1,
                   Byp ? 32'hDEADBEEF : 32'h0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h11, 1'b0,
                   1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h33,
                   32'h11, 1'b1, 32'h11, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd3, 32'h11, 1'b0,
                   1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h33,
                   32'h22, 1'b1, 32'h22, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h33, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1,
                   1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF,
                   32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 5'd9, 32'hBAD, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 5'd9, 32'hBAD, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b0, 5'd9, 32'hBAD, 1'b0,
                   1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0,
                   32'h0, 1'b1, 32'h55, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 5'd4, 32'h4444, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h99,
                   32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 1'b1, 32'h99, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd9, 32'h1, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 1'b0, 32'h33, 1'b1, 1'b1};

      #1;
      for (int i = 0; i < NumVec; i++) begin
         drive(vecs[i]);
         #2;
         if (vecs[i].c1) check($sformatf("vec%0d.read_data_1", i), read_data_1, vecs[i].e1);
         if (vecs[i].c2) check($sformatf("vec%0d.read_data_2", i), read_data_2, vecs[i].e2);
         check($sformatf("vec%0d.load_related", i), {31'h0, load_related},
               {31'h0, vecs[i].el});
         tick();
      end

      // Randomized traffic over a small register window to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         rst            = ($urandom_range(0, 39) == 0);
         read_en_1      = $urandom_range(0, 3) != 0;
         read_addr_1    = 5'($urandom_range(0, 7));
         read_en_2      = $urandom_range(0, 3) != 0;
         read_addr_2    = 5'($urandom_range(0, 7));
         ex_write_en    = $urandom_range(0, 1) != 0;
         ex_write_addr  = 5'($urandom_range(0, 7));
         ex_write_data  = $urandom;
         ex_load_flag   = $urandom_range(0, 2) == 0;
         mem_write_en   = $urandom_range(0, 1) != 0;
         mem_write_addr = 5'($urandom_range(0, 7));
         mem_write_data = $urandom;
         wb_write_en    = $urandom_range(0, 1) != 0;
         wb_write_addr  = 5'($urandom_range(0, 7));
         wb_write_data  = $urandom;
         #2;
         s1 = ref_stall(read_en_1, read_addr_1);
         s2 = ref_stall(read_en_2, read_addr_2);
         if (!s1) check($sformatf("rnd%0d.read_data_1", n), read_data_1,
                        ref_read(read_en_1, read_addr_1));
         if (!s2) check($sformatf("rnd%0d.read_data_2", n), read_data_2,
                        ref_read(read_en_2, read_addr_2));
         check($sformatf("rnd%0d.load_related", n), {31'h0, load_related},
               {31'h0, s1 || s2});
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
